// File: rtl/crank_wheel_gen.sv
// Missing-tooth crank wheel generator: emits TOTAL_TEETH slots per revolution, the last
// MISSING_TEETH of which are gaps, with the slot length latched from tooth_period at each slot start.
//
// state | meaning
// IDLE  | stopped, waiting for enable
// LOW   | tooth slot, low half (vrout=0)
// HIGH  | tooth slot, high half (vrout=1)
// GAP   | missing-tooth slot (vrout=0, gap=1)
module crank_wheel_gen #(
    parameter int TOTAL_TEETH   = 60,
    parameter int MISSING_TEETH = 2,
    parameter int PERIOD_W      = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                enable,
    input  logic [PERIOD_W-1:0] tooth_period,
    input  logic [7:0]          start_slot,
    output logic                vrout,
    output logic [7:0]          tooth_idx,
    output logic                gap,
    output logic                rev_pulse,
    output logic                running
);

    localparam logic [7:0]          TOTAL_IDX = 8'(TOTAL_TEETH);
    localparam logic [7:0]          LAST_IDX  = 8'(TOTAL_TEETH - 1);
    localparam logic [7:0]          FIRST_GAP = 8'(TOTAL_TEETH - MISSING_TEETH);
    localparam logic [PERIOD_W-1:0] MIN_PER   = PERIOD_W'(2);
    localparam logic [PERIOD_W-1:0] ONE       = PERIOD_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_LOW, S_HIGH, S_GAP} state_t;

    state_t              state_q, state_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [PERIOD_W-1:0] per_q, per_d;
    logic [7:0]          idx_q, idx_d;
    logic                vrout_q, vrout_d;
    logic                gap_q, gap_d;
    logic                rev_q, rev_d;
    logic                running_q, running_d;

    logic [PERIOD_W-1:0] per_new;
    logic [7:0]          next_idx;
    logic [7:0]          start_idx;
    logic [7:0]          slot_idx;
    logic                slot_is_gap;
    logic                begin_slot;

    always_comb begin
        per_new     = (tooth_period < MIN_PER) ? MIN_PER : tooth_period;
        next_idx    = (idx_q == LAST_IDX) ? 8'd0 : 8'(idx_q + 8'd1);
        start_idx   = (start_slot < TOTAL_IDX) ? start_slot : 8'd0;
        slot_idx    = (state_q == S_IDLE) ? start_idx : next_idx;
        slot_is_gap = (slot_idx >= FIRST_GAP);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        per_d      = per_q;
        idx_d      = idx_q;
        vrout_d    = vrout_q;
        gap_d      = gap_q;
        rev_d      = 1'b0;
        running_d  = running_q;
        begin_slot = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    begin_slot = 1'b1;
                end
            end
            S_LOW: begin
                if (cnt_q == '0) begin
                    state_d = S_HIGH;
                    cnt_d   = per_q - (per_q >> 1) - ONE;
                    vrout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            S_HIGH, S_GAP: begin
                if (cnt_q == '0) begin
                    // enable is only honoured at the slot boundary so a slot is never truncated
                    if (enable) begin
                        begin_slot = 1'b1;
                    end else begin
                        state_d   = S_IDLE;
                        running_d = 1'b0;
                        vrout_d   = 1'b0;
                        gap_d     = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (begin_slot) begin
            idx_d     = slot_idx;
            per_d     = per_new;
            running_d = 1'b1;
            rev_d     = (slot_idx == 8'd0);
            gap_d     = slot_is_gap;
            vrout_d   = 1'b0;
            state_d   = slot_is_gap ? S_GAP : S_LOW;
            cnt_d     = slot_is_gap ? (per_new - ONE) : ((per_new >> 1) - ONE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            per_q     <= '0;
            idx_q     <= '0;
            vrout_q   <= 1'b0;
            gap_q     <= 1'b0;
            rev_q     <= 1'b0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            per_q     <= per_d;
            idx_q     <= idx_d;
            vrout_q   <= vrout_d;
            gap_q     <= gap_d;
            rev_q     <= rev_d;
            running_q <= running_d;
        end
    end

    assign vrout     = vrout_q;
    assign tooth_idx = idx_q;
    assign gap       = gap_q;
    assign rev_pulse = rev_q;
    assign running   = running_q;

endmodule

// File: tb/tb_crank_wheel_gen.sv
// Bench for crank_wheel_gen: a slot/offset reference model checked every cycle, plus directed
// measurements of edge spacing, phase lengths, start/stop behaviour, ramps and async reset.
module tb_crank_wheel_gen;

    localparam int TT = 60;
    localparam int MT = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic [31:0] tooth_period = 32'd100;
    logic [7:0]  start_slot = 8'd0;
    logic        vrout;
    logic [7:0]  tooth_idx;
    logic        gap;
    logic        rev_pulse;
    logic        running;

    crank_wheel_gen #(.TOTAL_TEETH(TT), .MISSING_TEETH(MT), .PERIOD_W(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .enable       (enable),
        .tooth_period (tooth_period),
        .start_slot   (start_slot),
        .vrout        (vrout),
        .tooth_idx    (tooth_idx),
        .gap          (gap),
        .rev_pulse    (rev_pulse),
        .running      (running)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    // reference model: which slot we are in and how far into it
    bit m_run = 1'b0;
    bit m_rev = 1'b0;
    int m_idx = 0;
    int m_off = 0;
    int m_per = 2;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic int eff_period();
        return (tooth_period < 32'd2) ? 2 : int'(tooth_period);
    endfunction

    function automatic logic [11:0] exp_vec();
        bit tooth;
        bit ev;
        bit eg;
        tooth = (m_idx < TT - MT);
        eg    = m_run && !tooth;
        ev    = m_run && tooth && (m_off >= m_per / 2);
        return {m_run, m_rev, eg, ev, 8'(m_idx)};
    endfunction

    function automatic logic [11:0] obs_vec();
        return {running, rev_pulse, gap, vrout, tooth_idx};
    endfunction

    task automatic model_edge();
        if (!m_run) begin
            m_rev = 1'b0;
            if (enable) begin
                m_idx = (int'(start_slot) < TT) ? int'(start_slot) : 0;
                m_per = eff_period();
                m_off = 0;
                m_run = 1'b1;
                m_rev = (m_idx == 0);
            end
        end else if (m_off == m_per - 1) begin
            if (enable) begin
                m_idx = (m_idx == TT - 1) ? 0 : m_idx + 1;
                m_per = eff_period();
                m_off = 0;
                m_rev = (m_idx == 0);
            end else begin
                m_run = 1'b0;
                m_rev = 1'b0;
            end
        end else begin
            m_off++;
            m_rev = 1'b0;
        end
    endtask

    task automatic model_reset();
        m_run = 1'b0;
        m_rev = 1'b0;
        m_idx = 0;
        m_off = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        cyc++;
        model_edge();
        @(negedge clk);
        check("cycle", 64'(obs_vec()), 64'(exp_vec()));
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 1000 && running; i++) tick();
        check(tag, 64'(running), 64'd0);
    endtask

    task automatic wait_high(input string tag);
        for (int i = 0; i < 1000 && !vrout; i++) tick();
        check(tag, 64'(vrout), 64'd1);
    endtask

    task automatic measure(input int tp, input int exp_low, input int exp_high);
        int lo;
        int hi;
        lo = 0;
        hi = 1;
        start_slot   = 8'd5;
        tooth_period = 32'(tp);
        enable       = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (vrout) break;
            lo++;
        end
        enable = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (!vrout) break;
            hi++;
        end
        check($sformatf("low_len_p%0d", tp), 64'(lo), 64'(exp_low));
        check($sformatf("high_len_p%0d", tp), 64'(hi), 64'(exp_high));
        wait_idle("measure_idle");
    endtask

    initial begin
        int   rises, bad_sp, sp300, last_rise, rev_cnt, first_rev, rev_gap, gap_cyc;
        logic prev_v;
        int   held_idx, n, ramp_r, nslots, slot_start, cur_exp;
        logic [7:0] prev_idx;
        int   ramp_q[$];

        repeat (3) @(negedge clk);
        check("reset_outputs", 64'(obs_vec()), 64'd0);
        rst_n = 1'b1;

        // constant period 100 from slot 0 for two revolutions
        tooth_period = 32'd100;
        start_slot   = 8'd0;
        enable       = 1'b1;
        rises = 0; bad_sp = 0; sp300 = 0; last_rise = -1;
        rev_cnt = 0; first_rev = -1; rev_gap = 0; gap_cyc = 0; prev_v = 1'b0;
        for (int k = 0; k < 12000; k++) begin
            tick();
            if (vrout && !prev_v) begin
                if (last_rise >= 0) begin
                    if (cyc - last_rise != ((tooth_idx == 8'd0) ? 300 : 100)) bad_sp++;
                    if (cyc - last_rise == 300) sp300++;
                end
                rises++;
                last_rise = cyc;
            end
            prev_v = vrout;
            if (rev_pulse) begin
                if (first_rev < 0) first_rev = cyc;
                else rev_gap = cyc - first_rev;
                rev_cnt++;
            end
            if (gap) gap_cyc++;
        end
        check("rises_2rev", 64'(rises), 64'd116);
        check("bad_spacing", 64'(bad_sp), 64'd0);
        check("gap_spacing_300", 64'(sp300), 64'd1);
        check("rev_count", 64'(rev_cnt), 64'd2);
        check("rev_interval", 64'(rev_gap), 64'd6000);
        check("gap_cycles", 64'(gap_cyc), 64'd400);

        // drop enable mid-HIGH: slot completes, then IDLE with index held
        tick();
        wait_high("stop_wait_high");
        enable   = 1'b0;
        held_idx = int'(tooth_idx);
        wait_idle("stop_idle");
        check("stop_idx_held", 64'(tooth_idx), 64'(held_idx));
        check("stop_vrout", 64'(vrout), 64'd0);

        // odd and degenerate periods
        measure(101, 50, 51);
        measure(0, 1, 1);
        measure(1, 1, 1);
        measure(7, 3, 4);

        // start at slot 57: one tooth plus two gap slots before slot 0
        tooth_period = 32'd10;
        start_slot   = 8'd57;
        enable       = 1'b1;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            tick();
            n++;
            if (rev_pulse) break;
        end
        check("start57_latency", 64'(n), 64'd31);
        check("start57_idx", 64'(tooth_idx), 64'd0);
        enable = 1'b0;
        wait_idle("start57_idle");

        // out-of-range start slot falls back to slot 0
        start_slot   = 8'd200;
        tooth_period = 32'd4;
        enable       = 1'b1;
        tick();
        check("start200_idx", 64'(tooth_idx), 64'd0);
        check("start200_rev", 64'(rev_pulse), 64'd1);

        // ramp: each slot sees a value one larger; junk written mid-slot must be ignored
        ramp_r = 50; nslots = 0; cur_exp = -1; slot_start = cyc; prev_idx = tooth_idx;
        for (int k = 0; k < 6000 && nslots < 40; k++) begin
            tick();
            if (tooth_idx != prev_idx) begin
                if (cur_exp >= 0) check("ramp_slot_len", 64'(cyc - slot_start), 64'(cur_exp));
                cur_exp    = (ramp_q.size() > 0) ? ramp_q.pop_front() : -1;
                slot_start = cyc;
                nslots++;
            end
            prev_idx = tooth_idx;
            if (m_off == m_per - 1) begin
                tooth_period = 32'(ramp_r);
                ramp_q.push_back(ramp_r);
                ramp_r++;
            end else if ($urandom_range(0, 7) == 0) begin
                tooth_period = $urandom_range(0, 400);
            end
        end
        check("ramp_slots", 64'(nslots), 64'd40);
        enable = 1'b0;
        wait_idle("ramp_idle");

        // async reset mid-HIGH, then clean restart from start_slot
        start_slot   = 8'd3;
        tooth_period = 32'd20;
        enable       = 1'b1;
        wait_high("rst_wait_high");
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check("async_reset", 64'(obs_vec()), 64'd0);
        repeat (2) @(negedge clk);
        check("reset_hold", 64'(obs_vec()), 64'd0);
        rst_n = 1'b1;
        tick();
        check("rst_restart_idx", 64'(tooth_idx), 64'd3);
        check("rst_restart_run", 64'(running), 64'd1);
        for (int k = 0; k < 100; k++) tick();

        // randomized periods, enables and start slots against the model
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 3) == 0) tooth_period = $urandom_range(0, 12);
            if ($urandom_range(0, 39) == 0) enable = ~enable;
            if ($urandom_range(0, 15) == 0) start_slot = 8'($urandom_range(0, 255));
            tick();
        end
        enable = 1'b0;
        wait_idle("final_idle");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/crank_wheel_gen.md
# crank_wheel_gen

Missing-tooth crank wheel signal generator: the transmit side of the crank-sync decoder. Produces a digital VR-style tooth train, with TOTAL_TEETH slots per revolution of which the last MISSING_TEETH are gaps, at a tooth period programmable per slot. Used as an on-chip stimulator and bench source for the `sync` decoder, and as a synthetic crank source on hardware without a real trigger wheel.

## Interface
- TOTAL_TEETH, 60: slots per revolution, including missing teeth; range 3..255.
- MISSING_TEETH, 2: gap slots at the end of each revolution; range 1..TOTAL_TEETH-2.
- PERIOD_W, 32: width of the tooth period input.

- clk  in  1  system clock; all state on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  run request.
- tooth_period  in  PERIOD_W  slot length in clk cycles; sampled at each slot start.
- start_slot  in  8  first slot index after leaving IDLE.
- vrout  out  1  generated tooth signal; rising edge marks a tooth.
- tooth_idx  out  8  current slot index, 0..TOTAL_TEETH-1.
- gap  out  1  high while in a missing-tooth slot.
- rev_pulse  out  1  one-cycle pulse on entry to slot 0.
- running  out  1  high while not IDLE.

## Operation
- States: IDLE, LOW, HIGH, GAP. Reset forces IDLE, and every output is 0: vrout, tooth_idx, gap, rev_pulse, running.
- Slot start (per_q latched from tooth_period):
  - per_q = max(tooth_period, 2).
  - low_len = per_q >> 1.
  - high_len = per_q - low_len.
- Tooth slot (idx < TOTAL_TEETH-MISSING_TEETH):
  - LOW for low_len cycles with vrout=0.
  - Then HIGH for high_len cycles with vrout=1.
- Gap slot (idx >= TOTAL_TEETH-MISSING_TEETH):
  - GAP for per_q cycles with vrout=0 and gap=1.
- Down-counter cnt (PERIOD_W bits) is loaded with len-1. The phase ends on the cycle where cnt==0.
- Slot end is the last cycle of HIGH or GAP:
  - If enable=1: idx <= (idx==TOTAL_TEETH-1) ? 0 : idx+1. Latch a new per_q and enter LOW or GAP according to the new idx.
  - If enable=0: go to IDLE. running<=0, vrout<=0, gap<=0. tooth_idx holds its last value.
- IDLE with enable=1:
  - idx <= (start_slot < TOTAL_TEETH) ? start_slot : 0.
  - Latch per_q and enter LOW or GAP. running<=1.
- rev_pulse=1 for exactly the first cycle of every slot-0 entry, including a start with start_slot=0.
- enable deasserting mid-slot has no effect until the slot end; the current slot always completes.
- Changes on tooth_period mid-slot are ignored until the next slot start. This allows per-tooth acceleration ramps.
- An async reset mid-slot aborts immediately to the reset values. No partial tooth is emitted after release.

## Timing
- All outputs are registered. No combinational paths from inputs to outputs.
- Start latency: enable sampled high in IDLE at edge T. From edge T, running=1, tooth_idx=start slot and the LOW (or GAP) state are visible. vrout rises at edge T+low_len.
- In steady state, the spacing of vrout rising edges is per_q for consecutive teeth. Across the gap (last real tooth to slot 0) the spacing is (MISSING_TEETH+1)*per_q at constant period.
- Period is per_q exactly. One revolution is TOTAL_TEETH*per_q cycles at constant period.
- Odd periods give the extra cycle to the high phase.
- tooth_idx, gap and rev_pulse change on the same edge as the slot's first LOW or GAP cycle.

## Test plan
- Constant period, defaults (60-2), period=100, start_slot=0:
  - 58 vrout rising edges per revolution, 100 cycles apart, then a 300-cycle gap between slot 57's rise and slot 0's rise.
  - rev_pulse every 6000 cycles.
  - gap=1 for 200 cycles per revolution.
- Odd and degenerate periods:
  - period=101 gives low 50 / high 51.
  - period=0 and period=1 both give low 1 / high 1 (per_q=2).
- Ramp: tooth_period increments by 1 each slot starting at 50, and is changed mid-slot. Each slot length equals the value present at its start; mid-slot changes have no effect.
- Start and stop:
  - start_slot=57 reaches slot 0 after one tooth plus two gap slots, with rev_pulse at that entry.
  - start_slot=200 starts at slot 0.
  - Dropping enable mid-HIGH completes that slot, then goes to IDLE with running=0.
- Reset: assert rst_n low mid-HIGH. All outputs go to 0 asynchronously, before the next clk edge. After release with enable=1, the generator restarts cleanly from start_slot.
- Loopback: drive the `sync` decoder (60/2 config) from vrout. The decoder reports synced within two revolutions and its tooth_period matches per_q.
